// File: rtl/data_mem_if.sv
// Data-memory port between the CPU core (master) and data_mem (slave).
// Holds the read/write strobes, the address and data buses, and the buffer status flags.
interface data_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              mem_read_i;
  logic              mem_write_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] mem_data_o;
  logic              stall_o;
  logic              idle_o;
  logic              overflow_o;

  modport master (
    output mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_data_o, stall_o, idle_o, overflow_o
  );

  modport slave (
    input  mem_read_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_data_o, stall_o, idle_o, overflow_o
  );
endinterface

// File: rtl/data_mem.sv
// Byte-addressed little-endian data memory. Writes are posted to a buffer that drains one byte per cycle.
// Combinational reads forward pending buffered bytes, so the only visible effect of the buffer is stall_o.
module data_mem #(
  parameter int WB_DEPTH = 4,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32
) (
  input  logic      clk,
  input  logic      rst,
  data_mem_if.slave bus
);
  localparam int PTR_W    = $clog2(WB_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int MEM_SIZE = 2 ** ADDR_W;

  typedef enum logic { IDLE, DRAIN } drainState_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wbEntry_t;

  logic [7:0]       memArray [MEM_SIZE];
  wbEntry_t         wbuf     [WB_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] countNext;
  logic [1:0]       byteIdx;
  drainState_t      state;
  logic             full;
  logic             push;
  logic             pop;
  logic             stallReg;
  logic             idleReg;
  logic             overflowReg;
  logic [ADDR_W-1:0] drainAddr;
  logic [7:0]        drainByte;
  logic [DATA_W-1:0] readData;

  assign full = (count == CNT_W'(WB_DEPTH));
  assign push = bus.mem_write_i && !full;
  assign pop  = (state == DRAIN) && (byteIdx == 2'd3);

  assign drainAddr = wbuf[head].addr + ADDR_W'(byteIdx);
  assign drainByte = wbuf[head].data[8*byteIdx +: 8];

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    countNext = count;
    if (push && !pop) begin
      countNext = count + CNT_W'(1);
    end else if (!push && pop) begin
      countNext = count - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      byteIdx     <= '0;
      stallReg    <= 1'b0;
      idleReg     <= 1'b1;
      overflowReg <= 1'b0;
    end else begin
      count    <= countNext;
      stallReg <= (countNext == CNT_W'(WB_DEPTH));
      idleReg  <= (countNext == '0);
      if (push) begin
        tail <= tail + PTR_W'(1);
      end
      if (bus.mem_write_i && full) begin
        overflowReg <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (count != '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          byteIdx <= byteIdx + 2'd1;
          if (pop) begin
            head <= head + PTR_W'(1);
            if (countNext == '0) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer payload needs no reset: count gates every use of an entry.
  always_ff @(posedge clk) begin
    if (push) begin
      wbuf[tail] <= {bus.mem_addr_i, bus.mem_data_i};
    end
  end

  // NOTE: the storage array is reset explicitly because the core may read any byte right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        memArray[i] <= 8'h00;
      end
    end else if (state == DRAIN) begin
      memArray[drainAddr] <= drainByte;
    end
  end

  // Oldest-to-youngest scan, so the youngest covering entry wins on overlap.
  function automatic logic [7:0] fwdByte(input logic [ADDR_W-1:0] byteAddr);
    logic [7:0]        result;
    logic [PTR_W-1:0]  idx;
    logic [ADDR_W-1:0] off;
    result = memArray[byteAddr];
    for (int j = 0; j < WB_DEPTH; j++) begin
      idx = head + PTR_W'(j);
      off = byteAddr - wbuf[idx].addr;
      if ((CNT_W'(j) < count) && (off < ADDR_W'(4))) begin
        result = wbuf[idx].data[8*int'(off[1:0]) +: 8];
      end
    end
    return result;
  endfunction

  always_comb begin
    readData = '0;
    if (bus.mem_read_i) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        readData[8*i +: 8] = fwdByte(bus.mem_addr_i + ADDR_W'(i));
      end
    end
  end

  assign bus.mem_data_o = readData;
  assign bus.stall_o    = stallReg;
  assign bus.idle_o     = idleReg;
  assign bus.overflow_o = overflowReg;
endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed steps followed by randomized write bursts.
// Expected read data comes from a flat 256-byte model of the memory the core should observe.
module tb_data_mem;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   edges;

  logic [7:0] refMem [256];

  data_mem_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  data_mem #(.WB_DEPTH(4), .ADDR_W(8), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refRead(input logic [7:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) begin
      b = a + 8'(i);
      w[8*i +: 8] = refMem[b];
    end
    return w;
  endfunction

  task automatic refWrite(input logic [7:0] a, input logic [31:0] d);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = a + 8'(i);
      refMem[b] = d[8*i +: 8];
    end
  endtask

  task automatic refClear();
    for (int i = 0; i < 256; i++) refMem[i] = 8'h00;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [7:0] a, input logic [31:0] d);
    bus.mem_read_i  = rd;
    bus.mem_write_i = wr;
    bus.mem_addr_i  = a;
    bus.mem_data_i  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read cycle: data is compared to the model mid-cycle.
  task automatic readStep(input string tag, input logic [7:0] a);
    drive(1'b1, 1'b0, a, 32'h0);
    #2;
    check(tag, bus.mem_data_o, refRead(a));
    tick();
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    while (!bus.idle_o && n < 50) begin
      tick();
      n++;
    end
    check("idle_timeout", 32'(bus.idle_o), 32'd1);
  endtask

  function automatic logic [7:0] pickAddr();
    case ($urandom_range(0, 3))
      0:       return 8'($urandom_range(0, 255));
      3:       return 8'($urandom_range(252, 255));
      default: return 8'($urandom_range(16, 23));
    endcase
  endfunction

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic        rdEn;
    int          nW;

    total = 0;
    bad   = 0;
    refClear();
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    rst = 1'b0;
    #23;
    check("reset_read0", bus.mem_data_o, 32'h0);
    check("reset_idle", 32'(bus.idle_o), 32'd1);
    check("reset_stall", 32'(bus.stall_o), 32'd0);
    check("reset_ovf", 32'(bus.overflow_o), 32'd0);
    rst = 1'b1;
    tick();

    // Forwarding of a freshly posted write, then the same word from the array.
    drive(1'b0, 1'b1, 8'h10, 32'h11223344);
    tick();
    refWrite(8'h10, 32'h11223344);
    drive(1'b1, 1'b0, 8'h10, 32'h0);
    #2;
    check("fwd_0x10", bus.mem_data_o, 32'h11223344);
    check("busy_idle", 32'(bus.idle_o), 32'd0);
    check("busy_stall", 32'(bus.stall_o), 32'd0);
    tick();
    drive(1'b1, 1'b0, 8'h11, 32'h0);
    #2;
    check("fwd_0x11", bus.mem_data_o, 32'h00112233);
    tick();
    waitIdle(edges);
    check("drain_edges", 32'(edges + 2), 32'd5);
    readStep("array_0x10", 8'h10);
    drive(1'b0, 1'b0, 8'h10, 32'h0);
    #2;
    check("noread_zero", bus.mem_data_o, 32'h0);
    tick();

    // Wrap-around write at the top of the address space.
    drive(1'b0, 1'b1, 8'hFE, 32'hAABBCCDD);
    tick();
    refWrite(8'hFE, 32'hAABBCCDD);
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    #2;
    check("wrap_fwd_0x00", bus.mem_data_o, 32'h0000AABB);
    tick();
    waitIdle(edges);
    readStep("wrap_0xFE", 8'hFE);
    readStep("wrap_0xFF", 8'hFF);
    drive(1'b1, 1'b0, 8'h00, 32'h0);
    #2;
    check("wrap_0x00", bus.mem_data_o, 32'h0000AABB);
    tick();

    // Back-to-back writes fill the buffer; the fifth is dropped.
    drive(1'b0, 1'b1, 8'h20, 32'h01010101); #2; check("b2b_stall1", 32'(bus.stall_o), 32'd0); tick();
    refWrite(8'h20, 32'h01010101);
    drive(1'b0, 1'b1, 8'h22, 32'h02020202); #2; check("b2b_stall2", 32'(bus.stall_o), 32'd0); tick();
    refWrite(8'h22, 32'h02020202);
    drive(1'b0, 1'b1, 8'h30, 32'h33333333); #2; check("b2b_stall3", 32'(bus.stall_o), 32'd0); tick();
    refWrite(8'h30, 32'h33333333);
    drive(1'b0, 1'b1, 8'h34, 32'h44444444); #2; check("b2b_stall4", 32'(bus.stall_o), 32'd0); tick();
    refWrite(8'h34, 32'h44444444);
    drive(1'b0, 1'b1, 8'h38, 32'h55555555); #2;
    check("full_stall", 32'(bus.stall_o), 32'd1);
    check("full_ovf_pre", 32'(bus.overflow_o), 32'd0);
    tick();
    drive(1'b1, 1'b0, 8'h20, 32'h0);
    #2;
    check("ovf_set", 32'(bus.overflow_o), 32'd1);
    check("youngest_0x20", bus.mem_data_o, 32'h02020101);
    tick();
    readStep("dropped_0x38", 8'h38);
    readStep("partial_0x36", 8'h36);
    waitIdle(edges);
    check("ovf_sticky", 32'(bus.overflow_o), 32'd1);
    readStep("array_0x20", 8'h20);
    readStep("array_0x34", 8'h34);

    // Reset two bytes into a drain discards the pending write.
    drive(1'b0, 1'b1, 8'h40, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 8'h00, 32'h0);
    tick();
    tick();
    tick();
    rst = 1'b0;
    refClear();
    drive(1'b1, 1'b0, 8'h40, 32'h0);
    #20;
    check("midrst_read", bus.mem_data_o, 32'h0);
    check("midrst_idle", 32'(bus.idle_o), 32'd1);
    rst = 1'b1;
    tick();
    readStep("postrst_0x40", 8'h40);
    readStep("postrst_0x10", 8'h10);
    #2;
    check("postrst_idle", 32'(bus.idle_o), 32'd1);
    check("postrst_ovf", 32'(bus.overflow_o), 32'd0);
    tick();

    // Read and write in one cycle returns the pre-write value.
    drive(1'b1, 1'b1, 8'h50, 32'h12345678);
    #2;
    check("rw_same_cycle", bus.mem_data_o, 32'h0);
    tick();
    refWrite(8'h50, 32'h12345678);
    readStep("rw_next_read", 8'h50);
    waitIdle(edges);

    // Random bursts of up to three writes with interleaved reads; never fills the buffer.
    for (int b = 0; b < 40; b++) begin
      nW = $urandom_range(1, 3);
      for (int w = 0; w < nW; w++) begin
        a    = pickAddr();
        d    = $urandom();
        rdEn = 1'($urandom_range(0, 1));
        drive(rdEn, 1'b1, a, d);
        #2;
        check("rnd_stall", 32'(bus.stall_o), 32'd0);
        check("rnd_rw_read", bus.mem_data_o, rdEn ? refRead(a) : 32'h0);
        tick();
        refWrite(a, d);
        if ($urandom_range(0, 1) == 1) readStep("rnd_fwd_read", pickAddr());
      end
      readStep("rnd_pend_read", pickAddr());
      waitIdle(edges);
      readStep("rnd_array_read", pickAddr());
    end
    #2;
    check("rnd_ovf", 32'(bus.overflow_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Byte-addressed, little-endian 256-byte data memory; the responder for the CPU core's data-memory port (read/write strobes, 8-bit address, 32-bit data).
- Reads are combinational, so the core's memory stage sees valM in the same cycle.
- Writes are posted into a small write buffer. The buffer drains into the storage array one byte per cycle.
- Reads forward pending buffered data, so the buffer is invisible to the core except through stall_o.

Parameters:
- WB_DEPTH, 4, number of posted-write entries (power of two, >=2)
- ADDR_W, 8, address width; storage size is 2**ADDR_W bytes
- DATA_W, 32, word width; fixed at 4 bytes

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-low
- mem_read_i  input  1  read strobe from core
- mem_write_i  input  1  write strobe from core
- mem_addr_i  input  ADDR_W  byte address of word access
- mem_data_i  input  DATA_W  write data from core
- mem_data_o  output  DATA_W  read data to core (combinational)
- stall_o  output  1  write buffer full; a write this cycle is not accepted
- idle_o  output  1  write buffer empty and no drain in progress
- overflow_o  output  1  sticky: a write arrived while full

Behaviour:
- Reset (rst low, asynchronous): all array bytes <= 0, buffer count/head/tail/byte counter <= 0, overflow_o <= 0. Outputs during reset: mem_data_o=0, stall_o=0, idle_o=1. A reset asserted mid-drain discards all pending writes.
- Word layout:
  - The word at address A occupies bytes A, A+1, A+2, A+3, each computed mod 2**ADDR_W.
  - Byte A holds bits [7:0]; byte A+3 holds bits [31:24].
  - Unaligned accesses are legal. An access at 0xFE wraps to bytes 0xFE, 0xFF, 0x00, 0x01.
- Write accept:
  - Condition: on a rising edge with mem_write_i=1 and count<WB_DEPTH, push {addr, data} at tail; tail++ (mod WB_DEPTH).
  - Write latency: visible to reads on the following cycle via forwarding.
- Write drop: mem_write_i=1 while count==WB_DEPTH drops the write and sets overflow_o=1 until reset.
- Drain FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN when count>0.
  - In DRAIN, each cycle writes byte k (data[8k+7:8k]) of the head entry to array[head.addr+k] and increments k.
  - When k==3, pop head (head++), reset k=0, stay in DRAIN if count after the pop/push is >0, else go to IDLE.
  - Each entry takes exactly 4 cycles to drain.
- Simultaneous push and pop in one cycle: count is unchanged.
- Full push: allowed in the same cycle as a pop only if count<WB_DEPTH before the edge; stall_o is evaluated from the pre-edge count.
- stall_o = (count==WB_DEPTH). idle_o = (count==0), which implies state IDLE.
- Read (mem_read_i=1):
  - For each byte i in 0..3, the byte comes from the youngest valid buffer entry whose 4-byte span (wrapped) covers A+i. If no entry covers it, the byte comes from array[A+i].
  - Partially drained head bytes are still forwarded; the values are identical to the array, so either source is correct.
- Read with mem_read_i=0: mem_data_o=0.
- Read and write in the same cycle: mem_data_o reflects state before the write. The write is pushed at the edge.
- count is width clog2(WB_DEPTH)+1 and never exceeds WB_DEPTH; pointers wrap mod WB_DEPTH.

Test Plan:
- Reset then read 0x00 -> mem_data_o=0x00000000, idle_o=1, stall_o=0, overflow_o=0.
- Write 0x11223344 to 0x10, read 0x10 the next cycle -> 0x11223344 (forwarded). Read 0x11 -> 0x00112233. After 4 idle cycles idle_o=1 and a read of 0x10 still gives 0x11223344 (from array).
- Write 0xAABBCCDD to 0xFE -> after drain: byte 0xFE=0xDD, 0xFF=0xCC, 0x00=0xBB, 0x01=0xAA. Read 0x00 -> 0x0000AABB.
- Back-to-back writes, 5 cycles, WB_DEPTH=4:
  - stall_o=1 after the 4th accepted push (before any pop completes); the 5th write is dropped and overflow_o=1.
  - 0x20=0x01010101 then 0x22=0x02020202: read 0x20 -> 0x02020101 (youngest wins on overlap).
- Write 0xDEADBEEF to 0x40, assert rst low 2 cycles into the drain -> read 0x40 after release gives 0x00000000; idle_o=1; overflow_o=0.
- mem_read_i=1 and mem_write_i=1 at 0x50 (old 0x0, new 0x12345678) in one cycle -> mem_data_o=0x00000000 that cycle, 0x12345678 on the next read.
